// File: rtl/pipeline_control.sv
// Sequencing and hazard controller for the IF/ID/EX/WB pipeline around the execution stage.
// Interlocks on register RAW hazards, squashes wrong-path work on taken branches, drains on HALT.
module pipeline_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       id_halt,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic       id_wes,
  input  logic [3:0] id_dest,
  input  logic       id_branch,
  input  logic       bj,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       if_id_we,
  output logic       if_id_kill,
  output logic       id_ex_kill,
  output logic       wb_we,
  output logic [1:0] state,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  logic [1:0] state_q, state_d;
  logic       id_v_q, id_v_d;
  logic       ex_v_q, ex_v_d;
  logic       ex_we_q, ex_we_d;
  logic [3:0] ex_dest_q, ex_dest_d;
  logic       ex_br_q, ex_br_d;
  logic       wb_v_q, wb_v_d;
  logic       wb_we_q, wb_we_d;
  logic [3:0] wb_dest_q, wb_dest_d;

  logic [15:0] pend;
  logic        hz, tk, in_run;
  logic        go_tk, go_hz, go_halt, go_norm;

  // One bit per register number: a write to it is still in flight in EX or WB.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pend
      assign pend[gi] = (ex_v_q && ex_we_q && (ex_dest_q == 4'(gi))) ||
                        (wb_v_q && wb_we_q && (wb_dest_q == 4'(gi)));
    end
  endgenerate

  always_comb begin
    hz      = id_v_q && ((id_use1 && pend[id_rs1]) || (id_use2 && pend[id_rs2]));
    tk      = ex_v_q && ex_br_q && bj;
    in_run  = (state_q == S_RUN);
    go_tk   = in_run && tk;
    go_hz   = in_run && !tk && hz;
    go_halt = in_run && !tk && !hz && id_v_q && id_halt;
    go_norm = in_run && !tk && !hz && !(id_v_q && id_halt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      id_v_q    <= 1'b0;
      ex_v_q    <= 1'b0;
      ex_we_q   <= 1'b0;
      ex_dest_q <= 4'd0;
      ex_br_q   <= 1'b0;
      wb_v_q    <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_dest_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      id_v_q    <= id_v_d;
      ex_v_q    <= ex_v_d;
      ex_we_q   <= ex_we_d;
      ex_dest_q <= ex_dest_d;
      ex_br_q   <= ex_br_d;
      wb_v_q    <= wb_v_d;
      wb_we_q   <= wb_we_d;
      wb_dest_q <= wb_dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_RUN;
      S_RUN:          if (go_halt) state_d = S_DRAIN;
      S_DRAIN:        if (!ex_v_q && !wb_v_q) state_d = S_HALT;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    id_v_d    = id_v_q;
    ex_v_d    = ex_v_q;
    ex_we_d   = ex_we_q;
    ex_dest_d = ex_dest_q;
    ex_br_d   = ex_br_q;
    wb_v_d    = wb_v_q;
    wb_we_d   = wb_we_q;
    wb_dest_d = wb_dest_q;
    if (state_q == S_RUN || state_q == S_DRAIN) begin
      // WB always inherits EX; EX becomes a bubble unless ID advances normally.
      wb_v_d    = ex_v_q;
      wb_we_d   = ex_we_q;
      wb_dest_d = ex_dest_q;
      ex_v_d    = 1'b0;
      if (go_norm) begin
        id_v_d    = 1'b1;
        ex_v_d    = id_v_q;
        ex_we_d   = id_wes;
        ex_dest_d = id_dest;
        ex_br_d   = id_branch;
      end else if (!go_hz) begin
        id_v_d = 1'b0;
      end
    end else begin
      id_v_d = 1'b0;
      ex_v_d = 1'b0;
      wb_v_d = 1'b0;
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    if_id_we   = 1'b0;
    if_id_kill = 1'b0;
    id_ex_kill = 1'b0;
    if (go_tk) begin
      pc_we      = 1'b1;
      pc_sel     = 1'b1;
      if_id_kill = 1'b1;
      id_ex_kill = 1'b1;
    end else if (go_hz) begin
      id_ex_kill = 1'b1;
    end else if (go_halt) begin
      if_id_kill = 1'b1;
      id_ex_kill = 1'b1;
    end else if (go_norm) begin
      pc_we    = 1'b1;
      if_id_we = 1'b1;
    end else if (state_q == S_DRAIN) begin
      id_ex_kill = 1'b1;
    end
    wb_we = wb_v_q && wb_we_q;
    state = state_q;
    busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  end

endmodule
